// File: rtl/intersection_pkg.sv
// Shared types and default timing for the intersection phase controller.
package intersection_pkg;

  typedef enum logic [2:0] {
    ALL_RED_M   = 3'd0,
    MAIN_GREEN  = 3'd1,
    MAIN_YELLOW = 3'd2,
    ALL_RED_S   = 3'd3,
    SIDE_GREEN  = 3'd4,
    SIDE_YELLOW = 3'd5
  } phase_e;

  typedef struct packed {
    logic r;
    logic y;
    logic g;
  } lamp_t;

  localparam lamp_t LAMP_RED    = '{r: 1'b1, y: 1'b0, g: 1'b0};
  localparam lamp_t LAMP_YELLOW = '{r: 1'b0, y: 1'b1, g: 1'b0};
  localparam lamp_t LAMP_GREEN  = '{r: 1'b0, y: 1'b0, g: 1'b1};

  localparam int          CNT_W_DEF      = 8;
  localparam int unsigned T_MAIN_MIN_DEF = 50;
  localparam int unsigned T_YELLOW_DEF   = 20;
  localparam int unsigned T_ALL_RED_DEF  = 5;
  localparam int unsigned T_SIDE_DEF     = 30;
  localparam int unsigned T_PED_CLR_DEF  = 5;

endpackage

// File: rtl/intersection_phase_ctrl_phase_timer.sv
// Shared phase timer: restarts on every phase entry, flags the last cycle of a
// phase, and can park on that last cycle for open-ended phases.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             saturate,
  input  logic [CNT_W:0]   terminal,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  // Terminal is one bit wider so a phase of exactly 2^CNT_W cycles still fits.
  assign done = ({1'b0, count} == (terminal - (CNT_W + 1)'(1)));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (!(saturate && done)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/intersection_phase_ctrl.sv
// Intersection sequencer: main green rests, latched side/ped requests are
// served after a minimum main green, with yellow and all-red clearances.
module intersection_phase_ctrl
  import intersection_pkg::*;
#(
  parameter int          CNT_W      = CNT_W_DEF,
  parameter int unsigned T_MAIN_MIN = T_MAIN_MIN_DEF,
  parameter int unsigned T_YELLOW   = T_YELLOW_DEF,
  parameter int unsigned T_ALL_RED  = T_ALL_RED_DEF,
  parameter int unsigned T_SIDE     = T_SIDE_DEF,
  parameter int unsigned T_PED_CLR  = T_PED_CLR_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       side_req,
  input  logic       ped_req,
  output logic       main_r,
  output logic       main_y,
  output logic       main_g,
  output logic       side_r,
  output logic       side_y,
  output logic       side_g,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  phase_e           state, state_next;
  logic             side_pend, ped_pend, ped_served;
  logic [CNT_W-1:0] timer;
  logic [CNT_W:0]   terminal;
  logic             timer_done;
  logic             enter_side, exit_side;
  lamp_t            main_l, side_l;

  assign enter_side = (state_next == SIDE_GREEN) && (state != SIDE_GREEN);
  assign exit_side  = (state == SIDE_GREEN) && (state_next != SIDE_GREEN);

  always_comb begin
    terminal = (CNT_W + 1)'(T_ALL_RED);
    case (state)
      MAIN_GREEN:               terminal = (CNT_W + 1)'(T_MAIN_MIN);
      MAIN_YELLOW, SIDE_YELLOW: terminal = (CNT_W + 1)'(T_YELLOW);
      SIDE_GREEN:               terminal = (CNT_W + 1)'(T_SIDE);
      default:                  terminal = (CNT_W + 1)'(T_ALL_RED);
    endcase
  end

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_next != state),
    .saturate (state == MAIN_GREEN),
    .terminal (terminal),
    .count    (timer),
    .done     (timer_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ALL_RED_M;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ALL_RED_M:   if (timer_done) state_next = MAIN_GREEN;
      MAIN_GREEN:  if (timer_done && (side_pend || ped_pend)) state_next = MAIN_YELLOW;
      MAIN_YELLOW: if (timer_done) state_next = ALL_RED_S;
      ALL_RED_S:   if (timer_done) state_next = SIDE_GREEN;
      SIDE_GREEN:  if (timer_done) state_next = SIDE_YELLOW;
      SIDE_YELLOW: if (timer_done) state_next = ALL_RED_M;
      default:     state_next = ALL_RED_M;
    endcase
  end

  // Clearing on side-green entry wins over a request sampled on that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      side_pend  <= 1'b0;
      ped_pend   <= 1'b0;
      ped_served <= 1'b0;
      ped_ack    <= 1'b0;
    end else begin
      ped_ack <= enter_side && ped_pend;
      if (enter_side) begin
        side_pend <= 1'b0;
        ped_pend  <= 1'b0;
      end else if (state != SIDE_GREEN) begin
        if (side_req) side_pend <= 1'b1;
        if (ped_req)  ped_pend  <= 1'b1;
      end
      if (enter_side && ped_pend) ped_served <= 1'b1;
      else if (exit_side)         ped_served <= 1'b0;
    end
  end

  always_comb begin
    main_l = LAMP_RED;
    side_l = LAMP_RED;
    case (state)
      MAIN_GREEN:  main_l = LAMP_GREEN;
      MAIN_YELLOW: main_l = LAMP_YELLOW;
      SIDE_GREEN:  side_l = LAMP_GREEN;
      SIDE_YELLOW: side_l = LAMP_YELLOW;
      default: begin
        main_l = LAMP_RED;
        side_l = LAMP_RED;
      end
    endcase
  end

  assign {main_r, main_y, main_g} = main_l;
  assign {side_r, side_y, side_g} = side_l;
  // Walk drops T_PED_CLR cycles before side green ends to clear the crossing.
  assign walk  = (state == SIDE_GREEN) && ped_served &&
                 ({1'b0, timer} < (CNT_W + 1)'(T_SIDE - T_PED_CLR));
  assign phase = state;

endmodule

// File: tb/tb_intersection_phase_ctrl.sv
// Directed bench for intersection_phase_ctrl: phase durations, request
// latching, pedestrian service and lamp safety invariants.
module tb_intersection_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       side_req = 1'b0;
  logic       ped_req = 1'b0;
  logic       main_r, main_y, main_g, side_r, side_y, side_g, walk, ped_ack;
  logic [2:0] phase;

  int n_tests = 0;
  int n_fail = 0;
  int safety_err = 0;
  int walk_cnt = 0;
  int ack_cnt = 0;
  int len;
  int errs;

  intersection_phase_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .side_req (side_req),
    .ped_req  (ped_req),
    .main_r   (main_r),
    .main_y   (main_y),
    .main_g   (main_g),
    .side_r   (side_r),
    .side_y   (side_y),
    .side_g   (side_g),
    .walk     (walk),
    .ped_ack  (ped_ack),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (!$onehot({main_r, main_y, main_g}) || !$onehot({side_r, side_y, side_g}) ||
          (main_g && side_g) || ((main_g || main_y) && !side_r) ||
          ((side_g || side_y) && !main_r) || (walk && !side_g))
        safety_err++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] outs();
    return {main_r, main_y, main_g, side_r, side_y, side_g, walk, ped_ack};
  endfunction

  // Counts cycles spent in phase p starting from the current cycle.
  task automatic run_phase(input logic [2:0] p, input int budget, output int n);
    n = 0;
    while (phase == p && n < budget) begin
      n++;
      walk_cnt += int'(walk);
      ack_cnt  += int'(ped_ack);
      step();
    end
  endtask

  task automatic wait_phase(input string tag, input logic [2:0] p, input int budget);
    int n = 0;
    while (phase != p && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(phase), 32'(p));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    side_req = 1'b0;
    ped_req = 1'b0;
    step();
    step();
    rst = 1'b0;
    wait_phase("reset_to_main", 3'd1, 20);
  endtask

  initial begin
    // Reset state and idle behaviour.
    step();
    check("reset_phase", 32'(phase), 32'd0);
    check("reset_outs", 32'(outs()), 32'b100_100_00);
    rst = 1'b0;
    run_phase(3'd0, 20, len);
    check("idle_all_red_len", 32'(len), 32'd5);
    check("main_green_outs", 32'(outs()), 32'b001_100_00);
    walk_cnt = 0;
    ack_cnt = 0;
    run_phase(3'd1, 520, len);
    check("idle_hold_len", 32'(len), 32'd520);
    check("idle_walk", 32'(walk_cnt), 32'd0);
    check("idle_ack", 32'(ack_cnt), 32'd0);

    // Side request pulse at cycle 10 of main green.
    do_reset();
    for (int i = 0; i < 10; i++) step();
    side_req = 1'b1;
    step();
    side_req = 1'b0;
    walk_cnt = 0;
    ack_cnt = 0;
    run_phase(3'd1, 200, len);
    check("side_main_len", 32'(len + 11), 32'd50);
    check("side_yellow_outs", 32'(outs()), 32'b010_100_00);
    run_phase(3'd2, 100, len);
    check("main_yellow_len", 32'(len), 32'd20);
    run_phase(3'd3, 100, len);
    check("all_red_s_len", 32'(len), 32'd5);
    check("side_green_outs", 32'(outs()), 32'b100_001_00);
    run_phase(3'd4, 100, len);
    check("side_green_len", 32'(len), 32'd30);
    check("side_yel_outs", 32'(outs()), 32'b100_010_00);
    run_phase(3'd5, 100, len);
    check("side_yellow_len", 32'(len), 32'd20);
    run_phase(3'd0, 100, len);
    check("all_red_m_len", 32'(len), 32'd5);
    check("side_walk_none", 32'(walk_cnt), 32'd0);
    check("side_ack_none", 32'(ack_cnt), 32'd0);
    run_phase(3'd1, 200, len);
    check("side_return_hold", 32'(len), 32'd200);

    // Pedestrian request during main yellow.
    do_reset();
    side_req = 1'b1;
    step();
    side_req = 1'b0;
    wait_phase("ped_reach_yellow", 3'd2, 100);
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    wait_phase("ped_reach_side", 3'd4, 100);
    errs = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 0)  check("ped_ack_first", 32'(ped_ack), 32'd1);
      if (i == 1)  check("ped_ack_second", 32'(ped_ack), 32'd0);
      if (i == 24) check("walk_last_on", 32'(walk), 32'd1);
      if (i == 25) check("walk_first_off", 32'(walk), 32'd0);
      if (walk !== (i < 25)) errs++;
      if (phase !== 3'd4) errs++;
      step();
    end
    check("walk_pattern", 32'(errs), 32'd0);
    check("ped_after_side", 32'(phase), 32'd5);

    // Requests held only during side green are ignored.
    do_reset();
    side_req = 1'b1;
    step();
    side_req = 1'b0;
    wait_phase("ign_reach_side", 3'd4, 100);
    side_req = 1'b1;
    ped_req = 1'b1;
    wait_phase("ign_reach_syel", 3'd5, 40);
    side_req = 1'b0;
    ped_req = 1'b0;
    wait_phase("ign_back_main", 3'd1, 60);
    run_phase(3'd1, 200, len);
    check("ign_hold_len", 32'(len), 32'd200);

    // Continuous side request: steady 50-cycle main green.
    do_reset();
    side_req = 1'b1;
    wait_phase("cont_side1", 3'd4, 100);
    wait_phase("cont_main1", 3'd1, 100);
    run_phase(3'd1, 200, len);
    check("cont_main_len1", 32'(len), 32'd50);
    wait_phase("cont_main2", 3'd1, 200);
    run_phase(3'd1, 200, len);
    check("cont_main_len2", 32'(len), 32'd50);
    side_req = 1'b0;

    // Reset mid side green while serving a pedestrian.
    do_reset();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    wait_phase("mid_reach_side", 3'd4, 100);
    for (int i = 0; i < 12; i++) step();
    check("mid_walk_before", 32'(walk), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_reset_phase", 32'(phase), 32'd0);
    check("mid_reset_outs", 32'(outs()), 32'b100_100_00);
    run_phase(3'd0, 20, len);
    check("mid_all_red_len", 32'(len), 32'd5);
    run_phase(3'd1, 200, len);
    check("mid_main_hold", 32'(len), 32'd200);

    check("safety", 32'(safety_err), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
